// File: rtl/incdec_pipe.sv
// Elastic pipelined increment/decrement unit using the XOR-mask method (no adder).
// Define INCDEC_PIPE_SELFCHECK_EN to carry a native +1/-1 reference and raise a sticky fail flag.
module incdec_pipe #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_a,
  input  logic         in_dec,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_y,
  output logic         out_co,
  output logic         out_zero,
  output logic         fail
);

  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic         co;
    logic         zero;
    logic [W-1:0] y;
  } res_t;

  logic [W-1:0]      scan_c;
  logic [W-1:0]      mask_c;
  res_t              res_c;
  logic [STAGES-1:0] adv_c;
  logic              in_fire_c;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  res_t              st_q [STAGES];
  res_t              st_d [STAGES];

  // Decrement scans for the lowest 1, so invert and reuse the increment mask chain.
  always_comb begin
    scan_c    = in_dec ? ~in_a : in_a;
    mask_c    = '0;
    mask_c[0] = 1'b1;
    for (int unsigned i = 1; i < W; i++) begin
      mask_c[i] = mask_c[i-1] & scan_c[i-1];
    end
    res_c.y    = in_a ^ mask_c;
    res_c.co   = &scan_c;
    res_c.zero = ~|res_c.y;
  end

  // A stage advances when its item can leave; the chain starts at the output handshake.
  always_comb begin
    adv_c       = '0;
    adv_c[LAST] = v_q[LAST] & out_rdy;
    for (int i = int'(LAST) - 1; i >= 0; i--) begin
      adv_c[i] = v_q[i] & (~v_q[i+1] | adv_c[i+1]);
    end
  end

  assign in_rdy    = ~rst & (~v_q[0] | adv_c[0]);
  assign in_fire_c = in_vld & in_rdy;

  always_comb begin
    v_d  = v_q;
    st_d = st_q;
    v_d[0] = in_fire_c | (v_q[0] & ~adv_c[0]);
    if (in_fire_c) begin
      st_d[0] = res_c;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      v_d[i] = adv_c[i-1] | (v_q[i] & ~adv_c[i]);
      if (adv_c[i-1]) begin
        st_d[i] = st_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      st_q <= '{default: '0};
    end else begin
      v_q  <= v_d;
      st_q <= st_d;
    end
  end

  assign out_vld  = v_q[LAST];
  assign out_y    = st_q[LAST].y;
  assign out_co   = st_q[LAST].co;
  assign out_zero = st_q[LAST].zero;

`ifdef INCDEC_PIPE_SELFCHECK_EN
  localparam int unsigned WR = W + 1;

  logic [W:0] ref_c;
  logic [W:0] ref_q [STAGES];
  logic [W:0] ref_d [STAGES];
  logic       fail_q;
  logic       fail_d;

  // Reference travels in lockstep with the result, using the same advance controls.
  always_comb begin
    ref_c = in_dec ? ({1'b0, in_a} - WR'(1)) : ({1'b0, in_a} + WR'(1));
    ref_d = ref_q;
    if (in_fire_c) begin
      ref_d[0] = ref_c;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (adv_c[i-1]) begin
        ref_d[i] = ref_q[i-1];
      end
    end
    fail_d = fail_q | (out_vld & out_rdy & ({out_co, out_y} != ref_q[LAST]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q  <= '{default: '0};
      fail_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      fail_q <= fail_d;
    end
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_incdec_pipe.sv
// Self-checking bench for incdec_pipe: directed cases, random elastic traffic, reset flush,
// and exhaustive 8-bit sweeps on STAGES=1 and STAGES=4 instances.
module tb_incdec_pipe;

  localparam int unsigned W = 32;

  typedef struct {
    logic [63:0] y;
    logic        co;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic         in_vld, in_rdy, in_dec, out_vld, out_rdy, out_co, out_zero, fail;
  logic [W-1:0] in_a, out_y;

  logic       e_vld, e_dec, e_rdy;
  logic [7:0] e_a;
  logic       d1_in_rdy, d1_vld, d1_co, d1_zero, d1_fail;
  logic [7:0] d1_y;
  logic       d4_in_rdy, d4_vld, d4_co, d4_zero, d4_fail;
  logic [7:0] d4_y;

  int checks = 0;
  int errors = 0;
  int n_in = 0, n_out = 0, n1_in = 0, n1_out = 0, n4_in = 0, n4_out = 0;
  int acc, n, cyc, start;
  exp_t q[$], q1[$], q4[$];

  always #5 clk = ~clk;

  incdec_pipe #(.W(W), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_dec(in_dec),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y), .out_co(out_co),
    .out_zero(out_zero), .fail(fail)
  );

  incdec_pipe #(.W(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_vld(e_vld), .in_rdy(d1_in_rdy), .in_a(e_a), .in_dec(e_dec),
    .out_vld(d1_vld), .out_rdy(e_rdy), .out_y(d1_y), .out_co(d1_co),
    .out_zero(d1_zero), .fail(d1_fail)
  );

  incdec_pipe #(.W(8), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_vld(e_vld), .in_rdy(d4_in_rdy), .in_a(e_a), .in_dec(e_dec),
    .out_vld(d4_vld), .out_rdy(e_rdy), .out_y(d4_y), .out_co(d4_co),
    .out_zero(d4_zero), .fail(d4_fail)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain modular arithmetic reference.
  function automatic exp_t model(input logic [63:0] a, input logic dec, input int w);
    exp_t        e;
    logic [63:0] m;
    m      = (64'd1 << w) - 64'd1;
    e.y    = (dec ? a - 64'd1 : a + 64'd1) & m;
    e.co   = dec ? (a == 64'd0) : (a == m);
    e.zero = (e.y == 64'd0);
    return e;
  endfunction

  // Scoreboards: transfers are decided at the next rising edge, observed here mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_vld && out_rdy) begin
        chk("out_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("y", 64'(out_y), e.y);
          chk("co", 64'(out_co), 64'(e.co));
          chk("zero", 64'(out_zero), 64'(e.zero));
          n_out++;
        end
      end
      if (in_vld && in_rdy) begin
        q.push_back(model(64'(in_a), in_dec, 32));
        n_in++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete();
    end else begin
      if (d1_vld && q1.size() != 0) begin
        e = q1.pop_front();
        chk("s1_y", 64'(d1_y), e.y);
        chk("s1_co", 64'(d1_co), 64'(e.co));
        chk("s1_zero", 64'(d1_zero), 64'(e.zero));
        n1_out++;
      end
      if (e_vld && d1_in_rdy) begin
        q1.push_back(model(64'(e_a), e_dec, 8));
        n1_in++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q4.delete();
    end else begin
      if (d4_vld && q4.size() != 0) begin
        e = q4.pop_front();
        chk("s4_y", 64'(d4_y), e.y);
        chk("s4_co", 64'(d4_co), 64'(e.co));
        chk("s4_zero", 64'(d4_zero), 64'(e.zero));
        n4_out++;
      end
      if (e_vld && d4_in_rdy) begin
        q4.push_back(model(64'(e_a), e_dec, 8));
        n4_in++;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic dec);
    int   k;
    logic took;
    k      = 0;
    in_a   = a;
    in_dec = dec;
    in_vld = 1'b1;
    do begin
      @(negedge clk);
      took = in_rdy;
      @(posedge clk);
      #1;
      k++;
    end while (!took && k < 100);
    chk("send_accept", 64'(took), 64'd1);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int k;
    k       = 0;
    out_rdy = 1'b1;
    in_vld  = 1'b0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_a = '0; in_dec = 1'b0; out_rdy = 1'b0;
    e_vld = 1'b0; e_a = '0; e_dec = 1'b0; e_rdy = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_co", 64'(out_co), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;

    // Latency: inc 7 -> 8 visible STAGES cycles after the accept cycle
    out_rdy = 1'b1;
    send(32'h0000_0007, 1'b0);
    @(negedge clk);
    chk("lat_early_vld", 64'(out_vld), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_vld", 64'(out_vld), 64'd1);
    chk("lat_y", 64'(out_y), 64'h8);
    @(posedge clk); #1;

    // Boundary operands
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0000, 1'b1);
    send(32'h0000_0100, 1'b1);
    drain();

    // Stall: 1..4 offered with out_rdy low
    out_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_vld = (acc < 4); in_a = 32'(acc + 1); in_dec = 1'b0;
      @(negedge clk);
      if (out_vld) chk("stall_y", 64'(out_y), 64'd2);
      if (in_vld && in_rdy) acc++;
      @(posedge clk); #1;
    end
    chk("stall_accepts", 64'(acc), 64'd2);
    chk("stall_in_rdy", 64'(in_rdy), 64'd0);
    out_rdy = 1'b1;
    n = 0;
    while (acc < 4 && n < 20) begin
      in_vld = 1'b1; in_a = 32'(acc + 1);
      @(negedge clk);
      if (in_vld && in_rdy) acc++;
      @(posedge clk); #1;
      n++;
    end
    drain();
    chk("stall_none_lost", 64'(n_out), 64'(n_in));

    // Random elastic traffic
    start = n_in;
    cyc = 0;
    while (n_in - start < 10000 && cyc < 60000) begin
      in_vld  = 1'($urandom % 2);
      out_rdy = 1'($urandom % 2);
      in_dec  = 1'($urandom % 2);
      case ($urandom % 8)
        0:       in_a = '0;
        1:       in_a = '1;
        2:       in_a = 32'h0000_0100;
        default: in_a = $urandom;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_op_count", 64'(n_in - start >= 10000), 64'd1);
    drain();
    chk("rand_in_out_match", 64'(n_out), 64'(n_in));
    chk("rand_fail", 64'(fail), 64'd0);

    // Asynchronous reset with two items in flight
    out_rdy = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", 64'(out_vld), 64'd0);
    chk("arst_fail", 64'(fail), 64'd0);
    chk("arst_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale_vld", 64'(out_vld), 64'd0);
      @(posedge clk); #1;
    end
    send(32'h10, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_vld && n < 10);
    chk("post_rst_vld", 64'(out_vld), 64'd1);
    chk("post_rst_y", 64'(out_y), 64'h11);
    @(posedge clk); #1;
    drain();

    // Exhaustive 8-bit sweep on STAGES=1 and STAGES=4
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) begin
        e_vld = 1'b1; e_a = 8'(a); e_dec = 1'(d);
        @(posedge clk); #1;
      end
    end
    e_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("s1_in_count", 64'(n1_in), 64'd512);
    chk("s1_out_count", 64'(n1_out), 64'd512);
    chk("s4_in_count", 64'(n4_in), 64'd512);
    chk("s4_out_count", 64'(n4_out), 64'd512);
    chk("s1_fail", 64'(d1_fail), 64'd0);
    chk("s4_fail", 64'(d4_fail), 64'd0);
    chk("final_fail", 64'(fail), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/incdec_pipe.md
Name: incdec_pipe

Overview:
- Parametrised, pipelined increment/decrement unit with valid/ready handshakes on both sides.
- The datapath does not use an adder. It uses the mask method instead: XOR the operand with an inclusive LSB-side mask ending at the first 0 bit (increment) or the first 1 bit (decrement).
- Sits between an operand producer and a consumer in counter/pointer datapaths, fully elastic, one result per cycle.
- Optional compiled-in checker compares every result against native `+1`/`-1` arithmetic.

Parameters:
- W, 32, operand/result width in bits (>= 2).
- STAGES, 2, number of register stages between input and output handshakes (1..4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  operand valid.
- in_rdy  output  1  unit can accept operand this cycle.
- in_a  input  W  operand.
- in_dec  input  1  0 = increment, 1 = decrement.
- out_vld  output  1  result valid.
- out_rdy  input  1  consumer accepts result this cycle.
- out_y  output  W  result, modulo 2^W.
- out_co  output  1  carry (increment of all-ones) or borrow (decrement of zero).
- out_zero  output  1  out_y == 0.
- fail  output  1  sticky self-check mismatch flag (see Optional Feature).

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst is high: all stage valids = 0, out_vld = 0, out_y = 0, out_co = 0, out_zero = 0, fail = 0.
  - in_rdy = 0 while rst is asserted. It may go to 1 on the first cycle after deassertion.
- Accept/deliver: an input transfer occurs when in_vld & in_rdy. An output transfer occurs when out_vld & out_rdy.
- Increment:
  - mask = inclusive bits [k:0], where k is the index of the lowest 0 in in_a; y = in_a ^ mask.
  - If in_a is all ones: mask = all ones, y = 0, co = 1.
- Decrement:
  - Same, with k the index of the lowest 1.
  - If in_a = 0: y = all ones, co = 1.
- Where computation happens: y, co and zero are computed combinationally at the input and captured into stage 0 on accept. Stages 1..STAGES-1 carry {y, co, zero} unchanged. The last stage drives the outputs.
- Latency: exactly STAGES cycles from input transfer to out_vld with no backpressure.
- Throughput: 1 per cycle.
- Per-stage valid bit v[i]. Stage i loads from i-1 when v[i-1] & (!v[i] | stage i advancing); the last stage advances on an output transfer.
  - in_rdy = !v[0] | stage 0 advancing, i.e. a chained ready. A combinational path from out_rdy to in_rdy is permitted.
- Stall: while out_vld & !out_rdy, out_y/out_co/out_zero hold stable and no item is dropped or duplicated.
- Capacity: STAGES items in flight. With out_rdy held low, in_rdy falls after STAGES accepts.
- Ordering: strict FIFO order.
- Simultaneous events: an input and an output transfer in the same cycle on a full pipe is legal, and occupancy stays STAGES.
- Reset mid-operation: all in-flight items are discarded, no output transfer occurs for them, and fail is cleared.
- Data registers need no reset beyond the output stage; valids must be reset.

Optional Feature:
- Macro: INCDEC_PIPE_SELFCHECK_EN.
- Defined:
  - The unit also computes the reference {co_ref, y_ref} = in_a + 1 or in_a - 1 (W+1-bit native arithmetic) at input and carries it through the stages alongside the result.
  - On every output transfer, if {out_co, out_y} != {co_ref, y_ref}, fail is set to 1 on the next edge.
  - fail is sticky until rst.
- Not defined: no reference datapath is instantiated and fail is tied to 0. Port list is identical in both builds.

Test Plan:
- W=32, STAGES=2, inc 0x0000_0007 → out_y=0x0000_0008, co=0, zero=0, out_vld exactly 2 cycles after accept.
- Inc 0xFFFF_FFFF → out_y=0x0000_0000, co=1, zero=1; dec 0x0000_0000 → out_y=0xFFFF_FFFF, co=1; dec 0x0000_0100 → 0x0000_00FF, co=0.
- Back-to-back inc of 1,2,3,4 with out_rdy low for 5 cycles:
  - in_rdy drops after 2 accepts; out_y stable at 2 during the stall.
  - After out_rdy=1, outputs 2,3,4,5 in order, one per cycle, none lost.
- Random in_vld/out_rdy (50% each), 10k mixed inc/dec ops: scoreboard matches in order; with INCDEC_PIPE_SELFCHECK_EN, fail stays 0.
- Assert rst with 2 items in flight: out_vld=0 and fail=0 immediately (asynchronous), no stale item after release; next op 0x10 inc → 0x11.
- W=8, STAGES=1 and STAGES=4, exhaustive 256 values × {inc, dec}: every result equals (a±1) mod 256, co set only for 0xFF inc / 0x00 dec, fail=0.
